// File: rtl/spi_slave_if.sv
// Signal bundle between spi_slave and its host logic / SPI pins.
// The slave modport is the responder's view; the master modport is the
// view of whatever drives the bus (host logic plus the SPI master pins).
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    // Handshakes:
    //  - tx: a word transfers into the holding register on a rising clk edge
    //    where tx_valid and tx_ready are both 1. tx_valid may rise regardless
    //    of tx_ready, and tx_data must stay stable while tx_valid waits.
    //  - rx: rx_valid is a one-cycle pulse, with no back-pressure. rx_data
    //    holds the word until the next pulse.
    logic                  CPOL;
    logic                  CPHA;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_err;
    logic                  busy;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic                  dbg_state;   // slave FSM state: 0 = IDLE, 1 = ACTIVE

    modport slave (
        input  CPOL, CPHA, tx_data, tx_valid, sclk, cs_n, mosi,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy,
               miso, miso_oe, dbg_state
    );

    modport master (
        output CPOL, CPHA, tx_data, tx_valid, sclk, cs_n, mosi,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy,
               miso, miso_oe, dbg_state
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder. sclk, cs_n and mosi are oversampled in the clk domain.
// The block exchanges one DATA_WIDTH word per frame, MSB first, in any
// CPOL/CPHA mode. A one-entry holding register supplies the next transmit
// word, so words can run back to back while cs_n stays low.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic drive_edge;
    logic cs_fall;
    logic cs_rise;

    // Frame state
    logic [0:0]            state_q,       state_d;
    logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic                  first_drive_q, first_drive_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,    rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,    tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,     rx_data_d;
    logic                  rx_valid_q,    rx_valid_d;
    logic                  underrun_q,    underrun_d;
    logic                  frame_err_q,   frame_err_d;

    // Transmit holding register
    logic [DATA_WIDTH-1:0] hold_q,        hold_d;
    logic                  hold_full_q,   hold_full_d;

    logic word_load;
    logic tx_write;

    // Bring the SPI pins into the clk domain and keep one cycle of history
    // for edge detection. cs_n resets to its idle (high) level, so busy
    // starts at 0 and a low cs_n at reset release reads as a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A leading edge leaves the idle level; a trailing edge returns to it.
    assign lead_edge   = (sclk_prev_q == bus.CPOL) && (sclk_s != bus.CPOL);
    assign trail_edge  = (sclk_prev_q != bus.CPOL) && (sclk_s == bus.CPOL);
    assign sample_edge = bus.CPHA ? trail_edge : lead_edge;
    assign drive_edge  = bus.CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;

    assign tx_write = bus.tx_valid & ~hold_full_q;

    // Next-state logic: frame FSM, shift registers, status pulses and holding register
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        first_drive_d = first_drive_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        frame_err_d   = 1'b0;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        word_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // sclk and mosi activity is ignored until the slave is selected.
                // A simultaneous sclk edge loses to the cs_n fall.
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    word_load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    // A partially clocked word is dropped. rx_data keeps the last
                    // complete word, and an unclocked tx word is discarded.
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    // Once a bit has been sampled, the next drive edge belongs
                    // to this word and must shift. For CPHA=0 this is what
                    // moves past the MSB shown since cs_n fell.
                    first_drive_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        word_load  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (drive_edge) begin
                    // The first drive edge after a load would otherwise shift
                    // away the new MSB before the master samples it.
                    if (first_drive_q) begin
                        first_drive_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A word load takes the holding register if it is full; otherwise it
        // sends zeros and flags the underrun.
        if (word_load) begin
            tx_shift_d    = hold_full_q ? hold_q : '0;
            underrun_d    = ~hold_full_q;
            bit_cnt_d     = '0;
            first_drive_d = 1'b1;
            hold_full_d   = 1'b0;
        end

        // A host write in the same cycle as a load wins the register after
        // the load has taken the old contents.
        if (tx_write) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    // Frame and holding-register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            first_drive_q <= 1'b0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            first_drive_q <= first_drive_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
            frame_err_q   <= frame_err_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
        end
    end

    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = ~cs_s;
    assign bus.miso_oe     = ~cs_s;
    assign bus.miso        = tx_shift_q[DATA_WIDTH-1];
    assign bus.dbg_state   = state_q;
endmodule
